serializer_arbiter: RTL

SERIALIZER_ARBITER -- requirements
Module: serializer_arbiter

---
 rtl/serializer_arbiter_if.sv | 31 +++
 rtl/serializer_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serializer_arbiter_if.sv
// Lane request and serialized byte stream bundle for serializer_arbiter.
// slave is the arbiter side, master is the requester/sink side.
interface serializer_arbiter_if;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [7:0]   data_out;
    logic         valid_out;
    logic [1:0]   lane_out;
    logic         sof_out;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output data_out,
        output valid_out,
        output lane_out,
        output sof_out
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  data_out,
        input  valid_out,
        input  lane_out,
        input  sof_out
    );
endinterface

// File: rtl/serializer_arbiter.sv
// Four-lane round-robin arbiter that serializes 32-bit words into
// back-to-back MSB-first bytes with sof marking the first byte.
module serializer_arbiter #(
    parameter logic [7:0] IDLE_DATA = 8'h00
) (
    input  logic               clk_4f,
    input  logic               reset,
    serializer_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic [1:0]  lane_q, lane_d;

    logic        allow;
    logic        grant_any;
    logic [1:0]  grant_lane;
    logic        xfer;
    logic [31:0] grant_word;

    // Circular search starting just after the last granted lane.
    always_comb begin
        grant_any  = 1'b0;
        grant_lane = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_any && bus.req_valid[last_grant_q + 2'(k)]) begin
                grant_any  = 1'b1;
                grant_lane = last_grant_q + 2'(k);
            end
        end
    end

    assign allow = !reset &&
                   (state_q == IDLE || byte_cnt_q == 2'd3);
    assign xfer  = allow && grant_any;

    assign grant_word    = bus.req_data[{grant_lane, 5'd0} +: 32];
    assign bus.req_ready = xfer ? (4'b0001 << grant_lane) : 4'b0000;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        data_d       = data_q;
        valid_d      = valid_q;
        sof_d        = sof_q;
        lane_d       = lane_q;
        if (xfer) begin
            state_d      = SEND;
            byte_cnt_d   = 2'd0;
            last_grant_d = grant_lane;
            word_d       = grant_word;
            data_d       = grant_word[31:24];
            valid_d      = 1'b1;
            sof_d        = 1'b1;
            lane_d       = grant_lane;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    data_d  = IDLE_DATA;
                end
                SEND: begin
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = IDLE;
                        byte_cnt_d = 2'd0;
                        valid_d    = 1'b0;
                        sof_d      = 1'b0;
                        data_d     = IDLE_DATA;
                    end else begin
                        // Word is kept left-aligned; next byte sits in [23:16].
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        data_d     = word_q[23:16];
                        word_d     = {word_q[23:0], 8'h00};
                        valid_d    = 1'b1;
                        sof_d      = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            last_grant_q <= 2'd3;
            word_q       <= 32'h0;
            data_q       <= IDLE_DATA;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            lane_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            lane_q       <= lane_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.sof_out   = sof_q;
    assign bus.lane_out  = lane_q;

endmodule
